// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// mem_access_ctrl : MEM-stage controller running a req/ack data-memory access
//                   and stalling the upstream pipeline while it is outstanding
// Revision 1.0
// ============================================================================
module mem_access_ctrl #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        valid_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] alu_res_i,
   input  logic [31:0] wr_data_i,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic        reg_write_i,
   input  logic [4:0]  rd_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic        stall_o,
   output logic        wb_valid_o,
   output logic [31:0] wb_pc_o,
   output logic [31:0] wb_data_o,
   output logic [4:0]  wb_rd_o,
   output logic        wb_reg_write_o,
   output logic        misalign_o,
   output logic        bus_err_o
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t     state_q;
   logic [7:0] cnt_q;

   logic w_mem_op;
   logic w_misal;
   logic w_tmo;

   assign w_mem_op = valid_i & (mem_read_i | mem_write_i);
   assign w_misal  = |alu_res_i[1:0];
   assign w_tmo    = (cnt_q == TMO_LAST);

   // Held low during reset so the whole interface reads zero while rst_i is asserted.
   always_comb begin
      stall_o = 1'b0;
      if (rst_i) begin
         case (state_q)
            IDLE:    stall_o = w_mem_op & ~w_misal;
            BUSY:    stall_o = ~mem_ack_i & ~w_tmo;
            default: stall_o = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q        <= IDLE;
         cnt_q          <= 8'd0;
         mem_req_o      <= 1'b0;
         mem_we_o       <= 1'b0;
         mem_addr_o     <= 32'd0;
         mem_wdata_o    <= 32'd0;
         wb_valid_o     <= 1'b0;
         wb_pc_o        <= 32'd0;
         wb_data_o      <= 32'd0;
         wb_rd_o        <= 5'd0;
         wb_reg_write_o <= 1'b0;
         misalign_o     <= 1'b0;
         bus_err_o      <= 1'b0;
      end else begin
         misalign_o <= 1'b0;
         bus_err_o  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!w_mem_op) begin
                  wb_valid_o     <= valid_i;
                  wb_pc_o        <= pc_i;
                  wb_data_o      <= alu_res_i;
                  wb_rd_o        <= rd_i;
                  wb_reg_write_o <= reg_write_i & valid_i;
               end else if (w_misal) begin
                  misalign_o     <= 1'b1;
                  wb_valid_o     <= 1'b0;
                  wb_reg_write_o <= 1'b0;
               end else begin
                  state_q        <= BUSY;
                  cnt_q          <= 8'd0;
                  mem_req_o      <= 1'b1;
                  mem_we_o       <= mem_write_i;
                  mem_addr_o     <= {alu_res_i[31:2], 2'b00};
                  mem_wdata_o    <= wr_data_i;
                  wb_valid_o     <= 1'b0;
                  wb_reg_write_o <= 1'b0;
               end
            end
            BUSY: begin
               // Ack is checked first so it wins over a coincident timeout.
               if (mem_ack_i) begin
                  state_q        <= IDLE;
                  mem_req_o      <= 1'b0;
                  wb_valid_o     <= 1'b1;
                  wb_pc_o        <= pc_i;
                  wb_rd_o        <= rd_i;
                  wb_data_o      <= mem_write_i ? alu_res_i : mem_rdata_i;
                  wb_reg_write_o <= mem_write_i ? 1'b0 : reg_write_i;
               end else if (w_tmo) begin
                  state_q        <= IDLE;
                  mem_req_o      <= 1'b0;
                  bus_err_o      <= 1'b1;
                  wb_valid_o     <= 1'b0;
                  wb_reg_write_o <= 1'b0;
               end else begin
                  cnt_q          <= cnt_q + 8'd1;
                  wb_valid_o     <= 1'b0;
                  wb_reg_write_o <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mem_access_ctrl : randomized self-checking bench for mem_access_ctrl
// Revision 1.0
// ============================================================================
module tb_mem_access_ctrl;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0;
   logic [31:0] pc = '0;
   logic [31:0] alu = '0;
   logic [31:0] wdat = '0;
   logic        mrd = 1'b0;
   logic        mwr = 1'b0;
   logic        rwr = 1'b0;
   logic [4:0]  rd = '0;
   logic        ack = 1'b0;
   logic [31:0] rdata = '0;

   logic        mem_req, mem_we, stall, wb_valid, wb_rw, misalign, bus_err;
   logic [31:0] mem_addr, mem_wdata, wb_pc, wb_data;
   logic [4:0]  wb_rd;

   int checks = 0;
   int fails  = 0;

   mem_access_ctrl #(.TIMEOUT(TMO)) dut (
      .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .pc_i(pc), .alu_res_i(alu),
      .wr_data_i(wdat), .mem_read_i(mrd), .mem_write_i(mwr), .reg_write_i(rwr),
      .rd_i(rd), .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_ack_i(ack), .mem_rdata_i(rdata),
      .stall_o(stall), .wb_valid_o(wb_valid), .wb_pc_o(wb_pc), .wb_data_o(wb_data),
      .wb_rd_o(wb_rd), .wb_reg_write_o(wb_rw), .misalign_o(misalign), .bus_err_o(bus_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One instruction through MEM; ack_dly = BUSY cycle carrying the ack (> TMO means never).
   task automatic test_instr(input logic v, input logic r_en, input logic w_en, input logic rw,
                             input logic [31:0] i_pc, input logic [31:0] i_alu,
                             input logic [31:0] i_wd, input logic [31:0] i_rdat,
                             input logic [4:0] i_rd, input int ack_dly);
      logic mem_op, misal;
      int stalls, exp_stalls;
      logic [31:0] exp_data;
      logic        exp_rw;
      valid = v; mrd = r_en; mwr = w_en; rwr = rw; pc = i_pc; alu = i_alu;
      wdat = i_wd; rd = i_rd; ack = 1'b0; rdata = $urandom;
      #1;
      mem_op = v & (r_en | w_en);
      misal  = (i_alu[1:0] != 2'b00);
      if (!mem_op || misal) begin
         checks++;
         if (stall !== 1'b0) begin fails++; $display("FAIL nomem_stall: got %b expected 0", stall); end
         tick();
         if (!mem_op) begin
            checks++;
            if ({wb_valid, wb_pc, wb_data, wb_rd, wb_rw, misalign, mem_req} !== {v, i_pc, i_alu, i_rd, rw & v, 1'b0, 1'b0}) begin
               fails++;
               $display("FAIL passthru: got v=%b pc=%h d=%h rd=%0d rw=%b mis=%b req=%b expected v=%b pc=%h d=%h rd=%0d rw=%b",
                        wb_valid, wb_pc, wb_data, wb_rd, wb_rw, misalign, mem_req, v, i_pc, i_alu, i_rd, rw & v);
            end
         end else begin
            checks++;
            if ({misalign, mem_req, wb_valid, wb_rw} !== 4'b1000) begin
               fails++;
               $display("FAIL misalign: got mis=%b req=%b v=%b rw=%b expected 1000", misalign, mem_req, wb_valid, wb_rw);
            end
         end
      end else begin
         stalls = 1;
         exp_stalls = (ack_dly >= 1 && ack_dly <= TMO) ? ack_dly : TMO;
         checks++;
         if ({stall, mem_req} !== 2'b10) begin
            fails++; $display("FAIL detect: got stall=%b req=%b expected stall=1 req=0", stall, mem_req);
         end
         tick();
         checks++;
         if ({mem_req, mem_we, mem_addr, mem_wdata, wb_valid} !== {1'b1, w_en, i_alu, i_wd, 1'b0}) begin
            fails++;
            $display("FAIL request: got req=%b we=%b a=%h d=%h wbv=%b expected 1 %b %h %h 0",
                     mem_req, mem_we, mem_addr, mem_wdata, wb_valid, w_en, i_alu, i_wd);
         end
         for (int k = 1; k <= TMO; k++) begin
            ack = (k == ack_dly);
            if (ack) rdata = i_rdat;
            #1;
            if (stall === 1'b1) stalls++;
            checks++;
            if ({mem_req, mem_addr} !== {1'b1, i_alu}) begin
               fails++; $display("FAIL busy_hold: got req=%b a=%h expected 1 %h", mem_req, mem_addr, i_alu);
            end
            tick();
            ack = 1'b0;
            if (k == ack_dly) begin
               exp_data = w_en ? i_alu : i_rdat;
               exp_rw   = w_en ? 1'b0 : rw;
               checks++;
               if ({mem_req, bus_err, wb_valid, wb_pc, wb_data, wb_rd, wb_rw} !== {2'b00, 1'b1, i_pc, exp_data, i_rd, exp_rw}) begin
                  fails++;
                  $display("FAIL complete: got req=%b err=%b v=%b pc=%h d=%h rd=%0d rw=%b expected 0 0 1 %h %h %0d %b",
                           mem_req, bus_err, wb_valid, wb_pc, wb_data, wb_rd, wb_rw, i_pc, exp_data, i_rd, exp_rw);
               end
               break;
            end else if (k == TMO) begin
               checks++;
               if ({mem_req, bus_err, wb_valid, wb_rw} !== 4'b0100) begin
                  fails++; $display("FAIL timeout: got req=%b err=%b v=%b rw=%b expected 0100", mem_req, bus_err, wb_valid, wb_rw);
               end
            end else begin
               checks++;
               if ({wb_valid, bus_err} !== 2'b00) begin
                  fails++; $display("FAIL bubble: got v=%b err=%b expected 00", wb_valid, bus_err);
               end
            end
         end
         checks++;
         if (stalls != exp_stalls) begin
            fails++; $display("FAIL stall_cycles: got %0d expected %0d", stalls, exp_stalls);
         end
      end
   endtask

   task automatic test_reset();
      valid = 1'b0; mrd = 1'b0; mwr = 1'b0;
      tick(); tick();
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, stall, wb_valid, wb_pc, wb_data, wb_rd, wb_rw, misalign, bus_err} !== '0) begin
         fails++; $display("FAIL reset_state: got req=%b stall=%b wbv=%b pc=%h expected all 0", mem_req, stall, wb_valid, wb_pc);
      end
      rst_n = 1'b1;
      valid = 1'b1; mrd = 1'b1; alu = 32'h100; rd = 5'd3; rwr = 1'b1;
      tick();
      checks++;
      if ({mem_req, mem_addr} !== {1'b1, 32'h100}) begin
         fails++; $display("FAIL reset_load_req: got req=%b a=%h expected 1 00000100", mem_req, mem_addr);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({mem_req, mem_we, mem_addr, stall, wb_valid, wb_rw, misalign, bus_err} !== '0) begin
         fails++; $display("FAIL reset_async: got req=%b a=%h stall=%b expected all 0", mem_req, mem_addr, stall);
      end
      tick();
      rst_n = 1'b1;
      valid = 1'b1; mrd = 1'b0; mwr = 1'b0; alu = 32'h55; rd = 5'd9; rwr = 1'b1; pc = 32'h8;
      ack = 1'b1; rdata = 32'hBAD0BAD0;
      tick();
      ack = 1'b0;
      checks++;
      if ({mem_req, wb_valid, wb_data, wb_rd} !== {1'b0, 1'b1, 32'h55, 5'd9}) begin
         fails++; $display("FAIL late_ack: got req=%b v=%b d=%h rd=%0d expected 0 1 00000055 9", mem_req, wb_valid, wb_data, wb_rd);
      end
   endtask

   task automatic test_alu_passthrough();
      test_instr(1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 32'h1234, 32'h0, 32'h0, 5'd5, 1);
      test_instr(1'b0, 1'b1, 1'b0, 1'b1, 32'h204, 32'h40, 32'h0, 32'h0, 5'd6, 1);
   endtask

   task automatic test_load_delay();
      test_instr(1'b1, 1'b1, 1'b0, 1'b1, 32'h300, 32'h40, 32'h0, 32'hDEADBEEF, 5'd7, 3);
   endtask

   task automatic test_back_to_back();
      test_instr(1'b1, 1'b0, 1'b1, 1'b1, 32'h400, 32'h10, 32'hA, 32'h0, 5'd1, 1);
      test_instr(1'b1, 1'b0, 1'b1, 1'b1, 32'h404, 32'h14, 32'hB, 32'h0, 5'd2, 1);
      test_instr(1'b1, 1'b1, 1'b1, 1'b1, 32'h408, 32'h18, 32'hC, 32'h77, 5'd4, 2);
   endtask

   task automatic test_misaligned();
      test_instr(1'b1, 1'b1, 1'b0, 1'b1, 32'h500, 32'h42, 32'h0, 32'h0, 5'd8, 1);
      test_instr(1'b0, 1'b0, 1'b0, 1'b0, 32'h504, 32'h0, 32'h0, 32'h0, 5'd0, 1);
      checks++;
      if (misalign !== 1'b0) begin fails++; $display("FAIL misalign_pulse: got %b expected 0", misalign); end
   endtask

   task automatic test_timeout();
      test_instr(1'b1, 1'b1, 1'b0, 1'b1, 32'h600, 32'h80, 32'h0, 32'h0, 5'd10, TMO + 1);
      test_instr(1'b1, 1'b0, 1'b0, 1'b1, 32'h604, 32'h99, 32'h0, 32'h0, 5'd11, 1);
      checks++;
      if (bus_err !== 1'b0) begin fails++; $display("FAIL bus_err_pulse: got %b expected 0", bus_err); end
      test_instr(1'b1, 1'b1, 1'b0, 1'b1, 32'h608, 32'h84, 32'h0, 32'h12345678, 5'd12, TMO);
   endtask

   task automatic test_random();
      for (int n = 0; n < 80; n++) begin
         int          kind;
         logic [31:0] a;
         kind = $urandom_range(0, 4);
         a = $urandom;
         if (kind != 4) a = a & ~32'h3;
         else if (a[1:0] == 2'b00) a = a | 32'h1;
         test_instr(kind == 0 ? 1'($urandom_range(0, 1)) : 1'b1,
                    kind == 1 || kind == 3 || (kind == 4 && a[2]),
                    kind == 2 || kind == 3 || (kind == 4 && !a[2]),
                    1'($urandom_range(0, 1)), $urandom, a, $urandom, $urandom,
                    5'($urandom_range(0, 31)), $urandom_range(1, TMO + 1));
      end
   endtask

   initial begin
      test_reset();
      test_alu_passthrough();
      test_load_delay();
      test_back_to_back();
      test_misaligned();
      test_timeout();
      test_random();
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

MEM-stage controller: the consumer end of the EX/MEM pipeline register and the source of the stall that freezes it. It takes the instruction held in EX/MEM, runs a variable-latency data-memory transaction over a req/ack handshake, and drives the MEM/WB register outputs. It holds `stall_o` high while a load or store is outstanding, so IF/ID, ID/EX and EX/MEM freeze, and inserts bubbles into MEM/WB until the access completes.

## Interface
- `TIMEOUT`, default 255: BUSY cycles without ack before the access is abandoned; range 1..255.
- `clk_i` in 1: clock. All state updates on the rising edge.
- `rst_i` in 1: asynchronous, active-low reset.
- `valid_i` in 1: EX/MEM holds a live instruction; 0 means a flushed bubble.
- `pc_i` in 32: instruction PC from EX/MEM.
- `alu_res_i` in 32: ALU result; the memory address for loads and stores.
- `wr_data_i` in 32: store data.
- `mem_read_i` in 1: instruction is a load.
- `mem_write_i` in 1: instruction is a store.
- `reg_write_i` in 1: instruction writes the register file.
- `rd_i` in 5: destination register.
- `mem_req_o` out 1: data-memory request.
- `mem_we_o` out 1: 1 = write, 0 = read.
- `mem_addr_o` out 32: word address, with `[1:0]` = 0.
- `mem_wdata_o` out 32: write data.
- `mem_ack_i` in 1: single-cycle completion pulse.
- `mem_rdata_i` in 32: read data, valid when `mem_ack_i` = 1.
- `stall_o` out 1: freeze IF/ID, ID/EX and EX/MEM.
- `wb_valid_o` out 1: MEM/WB holds a live instruction.
- `wb_pc_o` out 32: MEM/WB PC.
- `wb_data_o` out 32: MEM/WB result.
- `wb_rd_o` out 5: MEM/WB destination register.
- `wb_reg_write_o` out 1: MEM/WB register-file write enable.
- `misalign_o` out 1: one-cycle pulse, misaligned access dropped.
- `bus_err_o` out 1: one-cycle pulse, access timed out.

## Operation
- FSM states: IDLE and BUSY.
- **Memory op:** `valid_i` & (`mem_read_i` | `mem_write_i`). If both read and write are set, it is a store; the read is ignored.
- **Reset:** every output and register goes to 0, state goes to IDLE, timeout counter goes to 0. A reset mid-transaction drops `mem_req_o` immediately and abandons the access; a late ack is ignored.
- **IDLE, no memory op:**
  - Next edge: MEM/WB <= {`valid_i`, `pc_i`, `alu_res_i`, `rd_i`, `reg_write_i` & `valid_i`}.
  - `stall_o` = 0.
- **IDLE, memory op with `alu_res_i[1:0]` != 0:**
  - No request is issued; `stall_o` = 0.
  - Next edge: `misalign_o` = 1 and a bubble goes into MEM/WB (`wb_valid_o` = 0, `wb_reg_write_o` = 0).
- **IDLE, aligned memory op:**
  - `stall_o` = 1.
  - Next edge: state -> BUSY, `mem_req_o` = 1, `mem_we_o` = `mem_write_i`, `mem_addr_o`/`mem_wdata_o` latched, counter = 0, bubble into MEM/WB.
- **BUSY:**
  - `mem_req_o`, `mem_we_o`, `mem_addr_o` and `mem_wdata_o` are held stable until the request ends.
  - Counter increments each cycle without ack.
- **BUSY, `mem_ack_i` = 1:**
  - `stall_o` = 0 in that cycle, so EX/MEM advances on the same edge.
  - Next edge: `mem_req_o` = 0, state -> IDLE.
  - Load: MEM/WB <= {1, `pc_i`, `mem_rdata_i`, `rd_i`, `reg_write_i`}.
  - Store: MEM/WB <= {1, `pc_i`, `alu_res_i`, `rd_i`, 0}.
- **BUSY, counter == `TIMEOUT` - 1, no ack:**
  - `stall_o` = 0 in that cycle.
  - Next edge: `mem_req_o` = 0, state -> IDLE, `bus_err_o` = 1, bubble into MEM/WB.
  - If ack and timeout coincide, ack wins.
- `mem_ack_i` in IDLE is ignored.
- EX/MEM inputs are stable while `stall_o` = 1; the block does not re-latch them in BUSY.

## Timing
- `stall_o` is combinational from state, the EX/MEM inputs and `mem_ack_i`. Every other output is registered.
- Non-memory instruction: 1 cycle EX/MEM -> MEM/WB, no stall.
- Memory op, ack in the first BUSY cycle: 2 cycles with 1 stall cycle. Each extra cycle of ack delay adds 1 stall cycle.
- Timeout: `stall_o` stays high for exactly `TIMEOUT` cycles (the IDLE detect cycle plus `TIMEOUT` - 1 BUSY cycles), then drops in the final BUSY cycle.
- Back-to-back memory ops: the second op's IDLE detect cycle immediately follows the ack edge, so the bus shows a 1-cycle `mem_req_o` gap between requests.
- `misalign_o` and `bus_err_o` are high for exactly one cycle per event.

## Test plan
- **Reset mid-access:** reset low for 2 cycles, then a load to 0x100; assert reset while BUSY -> all outputs 0 asynchronously; an ack arriving after reset releases has no effect.
- **ALU pass-through:** ALU op with `alu_res_i`=0x1234, `rd_i`=5, `reg_write_i`=1 -> next cycle `wb_data_o`=0x1234, `wb_rd_o`=5, `wb_reg_write_o`=1, `stall_o` never high.
- **Load, ack after 3 BUSY cycles:** load addr 0x40, `mem_rdata_i`=0xDEADBEEF -> `stall_o` high 3 cycles, `mem_req_o` high 3 cycles with `mem_we_o`=0, then `wb_data_o`=0xDEADBEEF and `wb_valid_o`=1.
- **Back-to-back stores:** store 0x10 then 0x14 (`wr_data_i`=0xA, 0xB), each acked in the first BUSY cycle -> two requests with correct addr/data, one idle cycle between them, `wb_reg_write_o`=0 both times.
- **Misaligned:** load to 0x42 -> no `mem_req_o`, `misalign_o` pulse, bubble in MEM/WB, no stall.
- **Timeout:** `TIMEOUT`=4, no ack -> `stall_o` high 4 cycles, `bus_err_o` pulse, `mem_req_o` drops, next instruction proceeds; a second run with ack on the final BUSY cycle completes normally with no `bus_err_o`.
